// File: rtl/mem_access_stage.sv
// Execute-to-memory stage: SPARC V8 loads/stores over a req/ack data port.
// Define MEM_ATOMIC_EN to enable LDSTUB and SWAP (read then write).
module mem_access_stage #(
  parameter int unsigned WAIT_LIMIT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MEM_valid_in,
  input  logic [1:0]  MEM_op_in,
  input  logic [5:0]  MEM_op3_in,
  input  logic [63:0] MEM_res_in,
  input  logic [31:0] MEM_store_data_in,
  input  logic [4:0]  MEM_rd_in,
  output logic        MEM_stall_out,
  output logic        dmem_req_out,
  output logic        dmem_we_out,
  output logic [31:0] dmem_addr_out,
  output logic [3:0]  dmem_be_out,
  output logic [31:0] dmem_wdata_out,
  input  logic [31:0] dmem_rdata_in,
  input  logic        dmem_ack_in,
  output logic        MEM_wb_valid_out,
  output logic        MEM_wb_we_out,
  output logic [4:0]  MEM_wb_rd_out,
  output logic [31:0] MEM_wb_data_out,
  output logic        MEM_trap_out,
  output logic [1:0]  MEM_trap_cause_out,
  output logic [31:0] MEM_trap_addr_out
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_ATOM_WR
  } state_t;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [7:0] LP_LAST = 8'(WAIT_LIMIT - 1);
  localparam bit LP_TMO_EN = (WAIT_LIMIT != 0);

  state_t r_state;
  state_t w_next;

  logic        r_we;
  logic [31:0] r_addr;
  logic [3:0]  r_be;
  logic [31:0] r_wdata;
  logic [31:0] r_ea;
  logic [4:0]  r_rd;
  logic [1:0]  r_sz;
  logic        r_sx;
  logic        r_is_ld;
  logic        r_atom;
  logic        r_gap;
  logic [7:0]  r_cnt;
  logic [31:0] r_ld_data;

  logic        r_wb_valid;
  logic        r_wb_we;
  logic [4:0]  r_wb_rd;
  logic [31:0] r_wb_data;
  logic        r_trap;
  logic [1:0]  r_trap_cause;
  logic [31:0] r_trap_addr;

  logic        w_ld;
  logic        w_st;
  logic        w_atom;
  logic        w_ill;
  logic        w_sx;
  logic [1:0]  w_sz;
  logic        w_memop;
  logic        w_mis;
  logic        w_acc;
  logic [3:0]  w_be;
  logic [31:0] w_wd;
  logic [31:0] w_ea;
  logic        w_req;
  logic        w_ack;
  logic        w_limit;
  logic        w_tmo;
  logic [31:0] w_ext;
  logic        w_unused_hi;

  assign w_ea        = MEM_res_in[31:0];
  assign w_unused_hi = ^MEM_res_in[63:32];

  always_comb begin
    w_ld   = 1'b0;
    w_st   = 1'b0;
    w_atom = 1'b0;
    w_ill  = 1'b0;
    w_sx   = 1'b0;
    w_sz   = SZ_W;
    if (MEM_op_in == 2'b11) begin
      case (MEM_op3_in)
        6'b000000: w_ld = 1'b1;
        6'b000001: begin
          w_ld = 1'b1;
          w_sz = SZ_B;
        end
        6'b000010: begin
          w_ld = 1'b1;
          w_sz = SZ_H;
        end
        6'b001001: begin
          w_ld = 1'b1;
          w_sz = SZ_B;
          w_sx = 1'b1;
        end
        6'b001010: begin
          w_ld = 1'b1;
          w_sz = SZ_H;
          w_sx = 1'b1;
        end
        6'b000100: w_st = 1'b1;
        6'b000101: begin
          w_st = 1'b1;
          w_sz = SZ_B;
        end
        6'b000110: begin
          w_st = 1'b1;
          w_sz = SZ_H;
        end
`ifdef MEM_ATOMIC_EN
        6'b001101: begin
          w_atom = 1'b1;
          w_sz   = SZ_B;
        end
        6'b001111: w_atom = 1'b1;
`else
        6'b001101, 6'b001111: w_ill = 1'b1;
`endif
        default: ;
      endcase
    end
  end

  assign w_memop = w_ld | w_st | w_atom;
  assign w_mis   = w_memop &
                   (((w_sz == SZ_H) & w_ea[0]) |
                    ((w_sz == SZ_W) & (|w_ea[1:0])));
  assign w_acc   = MEM_valid_in & (r_state == S_IDLE);

  // Big-endian lanes: be[3] is the byte at offset 0.
  always_comb begin
    w_be = 4'b1111;
    w_wd = MEM_store_data_in;
    unique case (1'b1)
      (w_sz == SZ_B): begin
        w_be = 4'b1000 >> w_ea[1:0];
        w_wd = {4{MEM_store_data_in[7:0]}};
      end
      (w_sz == SZ_H): begin
        w_be = w_ea[1] ? 4'b0011 : 4'b1100;
        w_wd = {2{MEM_store_data_in[15:0]}};
      end
      default: ;
    endcase
    if (w_atom && (w_sz == SZ_B))
      w_wd = 32'hFFFF_FFFF;
  end

  function automatic logic [31:0] f_extract(
    input logic [31:0] d,
    input logic [1:0]  lo,
    input logic [1:0]  sz,
    input logic        sx
  );
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    unique case (lo)
      2'd0:    b = d[31:24];
      2'd1:    b = d[23:16];
      2'd2:    b = d[15:8];
      default: b = d[7:0];
    endcase
    h = lo[1] ? d[15:0] : d[31:16];
    r = d;
    if (sz == SZ_B)
      r = sx ? {{24{b[7]}}, b} : {24'd0, b};
    else if (sz == SZ_H)
      r = sx ? {{16{h[15]}}, h} : {16'd0, h};
    return r;
  endfunction

  assign w_ext   = f_extract(dmem_rdata_in, r_ea[1:0], r_sz, r_sx);
  assign w_req   = (r_state == S_REQ) ||
                   ((r_state == S_ATOM_WR) && !r_gap);
  assign w_ack   = w_req & dmem_ack_in;
  assign w_limit = LP_TMO_EN && (r_cnt == LP_LAST);
  assign w_tmo   = w_req & ~dmem_ack_in & w_limit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_acc && w_memop && !w_mis)
          w_next = S_REQ;
      end
      S_REQ: begin
        if (w_ack)
          w_next = r_atom ? S_ATOM_WR : S_IDLE;
        else if (w_tmo)
          w_next = S_IDLE;
      end
      S_ATOM_WR: begin
        if (w_ack || w_tmo)
          w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_be         <= '0;
      r_wdata      <= '0;
      r_ea         <= '0;
      r_rd         <= '0;
      r_sz         <= SZ_W;
      r_sx         <= 1'b0;
      r_is_ld      <= 1'b0;
      r_atom       <= 1'b0;
      r_gap        <= 1'b0;
      r_cnt        <= '0;
      r_ld_data    <= '0;
      r_wb_valid   <= 1'b0;
      r_wb_we      <= 1'b0;
      r_wb_rd      <= '0;
      r_wb_data    <= '0;
      r_trap       <= 1'b0;
      r_trap_cause <= '0;
      r_trap_addr  <= '0;
    end else begin
      r_wb_valid <= 1'b0;
      r_trap     <= 1'b0;
      if (w_acc) begin
        if (w_ill || w_mis) begin
          r_trap       <= 1'b1;
          r_trap_cause <= w_ill ? 2'b11 : 2'b01;
          r_trap_addr  <= w_ea;
        end else if (w_memop) begin
          r_we    <= w_st;
          r_addr  <= {w_ea[31:2], 2'b00};
          r_be    <= w_be;
          r_wdata <= w_wd;
          r_ea    <= w_ea;
          r_rd    <= MEM_rd_in;
          r_sz    <= w_sz;
          r_sx    <= w_sx;
          r_is_ld <= w_ld | w_atom;
          r_atom  <= w_atom;
          r_gap   <= 1'b0;
          r_cnt   <= '0;
        end else begin
          r_wb_valid <= 1'b1;
          r_wb_we    <= (MEM_op_in != 2'b11) && (MEM_rd_in != 5'd0);
          r_wb_rd    <= MEM_rd_in;
          r_wb_data  <= w_ea;
        end
      end else if (w_ack && (r_state == S_REQ) && r_atom) begin
        r_ld_data <= w_ext;
        r_we      <= 1'b1;
        r_gap     <= 1'b1;
        r_cnt     <= '0;
      end else if (w_ack) begin
        r_we       <= 1'b0;
        r_wb_valid <= 1'b1;
        r_wb_we    <= r_is_ld && (r_rd != 5'd0);
        r_wb_rd    <= r_rd;
        r_wb_data  <= r_atom ? r_ld_data : (r_is_ld ? w_ext : 32'd0);
      end else if (w_tmo) begin
        r_we         <= 1'b0;
        r_trap       <= 1'b1;
        r_trap_cause <= 2'b10;
        r_trap_addr  <= r_ea;
      end else if (w_req) begin
        r_cnt <= r_cnt + 8'd1;
      end else if (r_state == S_ATOM_WR) begin
        r_gap <= 1'b0;
      end
    end
  end

  assign MEM_stall_out      = (r_state != S_IDLE);
  assign dmem_req_out       = w_req;
  assign dmem_we_out        = r_we;
  assign dmem_addr_out      = r_addr;
  assign dmem_be_out        = r_be;
  assign dmem_wdata_out     = r_wdata;
  assign MEM_wb_valid_out   = r_wb_valid;
  assign MEM_wb_we_out      = r_wb_we;
  assign MEM_wb_rd_out      = r_wb_rd;
  assign MEM_wb_data_out    = r_wb_data;
  assign MEM_trap_out       = r_trap;
  assign MEM_trap_cause_out = r_trap_cause;
  assign MEM_trap_addr_out  = r_trap_addr;

endmodule
